uart_tx_arbiter: RTL

- Shares one uart_ctrl_tx transmitter among N byte-stream requesters.
- Uses round-robin arbitration with per-message locking: a granted requester keeps the transmitter until it sends a byte flagged last, so multi-byte messages are never interleaved.
- Sits between client logic (debug printers, status reporters, echo paths) and the single UART TX pin driver.
- Sequences the core through its start/ready handshake, one byte at a time.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among N byte-stream requesters.
// A granted requester keeps the core until it sends a byte flagged last, or until the lock timeout.
module uart_tx_arbiter #(
  parameter int unsigned N            = 4,
  parameter int unsigned LOCK_TIMEOUT = 0,
  parameter int unsigned TW           = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_ready
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StArb,
    StIssue,
    StWaitLo,
    StWaitHi
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   ptr_q;
  logic [N-1:0]    grant_q;
  logic            last_q;
  logic [TW-1:0]   tmo_q;

  logic            found;
  logic [IW-1:0]   win_idx;
  logic [N-1:0]    win_oh;
  logic [IW:0]     cand;
  logic [IW-1:0]   ptr_next;
  logic            owner_valid;

  // Scan from the highest offset down so the candidate closest to the pointer is written last.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) begin
        cand = cand - (IW + 1)'(N);
      end
      if (req_valid[cand[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
    win_oh[win_idx] = found;
  end

  assign owner_valid = req_valid[owner_q];
  assign ptr_next    = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign tx_start    = (state_q == StIssue) && owner_valid && tx_ready;
  assign grant       = grant_q;
  assign busy        = (state_q != StArb);

  always_comb begin
    req_ready          = '0;
    req_ready[owner_q] = tx_start;
    tx_data            = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == IW'(i)) begin
        tx_data = req_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StArb;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      last_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (found) begin
            owner_q <= win_idx;
            grant_q <= win_oh;
            tmo_q   <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (tx_start) begin
            last_q  <= req_last[owner_q];
            tmo_q   <= '0;
            state_q <= StWaitLo;
          end else if (LOCK_TIMEOUT != 0 && !owner_valid) begin
            if (tmo_q == TmoLast) begin
              grant_q <= '0;
              ptr_q   <= ptr_next;
              tmo_q   <= '0;
              state_q <= StArb;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        // A start is issued only from StIssue, so the core never sees two starts per byte.
        StWaitLo: begin
          if (!tx_ready) begin
            state_q <= StWaitHi;
          end
        end
        StWaitHi: begin
          if (tx_ready) begin
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= ptr_next;
              state_q <= StArb;
            end else begin
              state_q <= StIssue;
            end
          end
        end
      endcase
    end
  end

endmodule
